slp_issue: RTL
==============

// Module: slp_issue
// PURPOSE
//  Upstream companion of the sleep unit. Accepts slp requests from the exec stage and clamps
//  the signed operand. Issues sleep_val/input_flag to the sleep unit and generates the
//  posedge_big_clk time-unit tick. Stalls exec until the sleep unit drops output_flag, then
//  pulses wake. Sits between the instruction executor and the sleep unit of each controller.
// PARAMETERS
//  CLK_DIV   16   clk cycles per time unit (>=2); period of posedge_big_clk
//  TU_W      16   width of free-running time-unit counter
//  SLP_MAX   999  saturation ceiling for sleep_val (fits 11 bits)
// PORTS
//  clk             in   1     system clock; all logic on posedge
//  reset           in   1     synchronous, active-high
//  run             in   1     1 = time advances; 0 = big-clock divider frozen
//  slp_req         in   1     exec requests sleep; held until slp_ack
//  slp_operand     in   11    signed two's-complement operand (-1024..1023)
//  slp_ack         out  1     1-cycle pulse: request accepted
//  exec_stall      out  1     high from accept until wake
//  wake            out  1     1-cycle pulse: sleep complete, exec may proceed
//  slp_err         out  1     1-cycle pulse: sleep unit failed to start
//  sleep_val       out  11    unsigned sleep length to sleep unit
//  input_flag      out  1     1-cycle start pulse to sleep unit
//  output_flag     in   1     sleep unit busy (is_sleeping)
//  posedge_big_clk out  1     1-cycle tick, once per CLK_DIV clk while run=1
//  time_unit       out  TU_W  count of big-clock ticks since reset, wraps
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, divider=0, time_unit=0. Reset mid-sleep aborts: no wake
//   pulse. Sleep unit has no reset, so output_flag may stay high; IDLE gating covers it.
//  Clamp: op<=0 -> zero-sleep; 1..SLP_MAX -> op; op>SLP_MAX -> SLP_MAX.
//  Divider: cnt++ each clk when run=1. At cnt==CLK_DIV-1: cnt<=0 and posedge_big_clk=1 next
//   cycle; time_unit++ (wraps to 0). run=0 holds cnt; no tick.
//  FSM (all outputs registered):
//   IDLE: slp_req & ~output_flag & op<=0 -> next cycle slp_ack=1, wake=1, no stall,
//     no input_flag; stay IDLE.
//     slp_req & ~output_flag & op>0 -> next cycle slp_ack=1, input_flag=1,
//     sleep_val=clamp(op), exec_stall=1; go START.
//     slp_req & output_flag -> no ack; request held (sleep unit busy).
//   START (1 cycle): output_flag=1 -> SLEEPING.
//     output_flag=0 -> slp_err=1, wake=1, exec_stall=0 next cycle -> IDLE.
//   SLEEPING: exec_stall=1; on output_flag 1->0 -> wake=1, exec_stall=0 next cycle -> IDLE.
//  sleep_val held stable from issue until next issue. input_flag never asserted outside
//   the issue cycle. slp_req outside IDLE is ignored (no ack).
//  Tick on the issue cycle is legal: the sleep unit prioritises input_flag. Sleep of N ends
//   on the Nth tick after start.
//  Latency: req -> ack/input_flag 1 cycle; final tick -> wake 2 cycles (sleep unit + edge).
//  Back-to-back: new req accepted in IDLE the cycle after wake.
// STRUCTURE
//  Shared package: FSM state enum (IDLE/START/SLEEPING), SLP_MAX, sleep_val width (11).
//  Sub-module: big_clk_gen (divider + time_unit counter; ports clk, reset, run,
//   posedge_big_clk, time_unit). FSM and clamp stay in slp_issue.
// TESTING (bench includes behavioural sleep unit model, CLK_DIV=4)
//  1. slp_req, op=3 -> ack+input_flag, sleep_val=3 next cycle; wake 2 clk after the 3rd tick.
//  2. op=-5 and op=0 -> ack+wake same cycle, input_flag never asserts, exec_stall stays 0.
//  3. op=1500 -> sleep_val=999; op=999 -> 999; op=1 -> 1.
//  4. output_flag forced 1 in IDLE with req -> no ack; release -> ack next cycle.
//  5. Model ignores input_flag -> slp_err+wake pulse 2 cycles after issue, exec_stall drops.
//  6. Reset asserted mid-SLEEPING -> all outputs 0 next cycle, no wake; run=0 freezes
//     time_unit; time_unit wraps 0xFFFF -> 0.

Source files
------------

// File: rtl/slp_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slp_issue_pkg
// Brief    : Shared constants, FSM encoding and operand clamp for slp_issue.
// Revision : 1.0 - initial release
// ============================================================================
package slp_issue_pkg;

    localparam int c_SLP_VAL_W = 11;
    localparam int c_SLP_MAX   = 999;
    localparam int c_STATE_W   = 2;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE     = 2'd0;
    localparam state_t c_ST_START    = 2'd1;
    localparam state_t c_ST_SLEEPING = 2'd2;

    // Non-positive operands become a zero-length sleep; large ones saturate.
    function automatic logic [c_SLP_VAL_W-1:0] clamp_op(
        input logic signed [c_SLP_VAL_W-1:0] op,
        input logic        [c_SLP_VAL_W-1:0] max_val
    );
        logic [c_SLP_VAL_W-1:0] mag;
        logic [c_SLP_VAL_W-1:0] res;
        mag = op;
        if (op[c_SLP_VAL_W-1] || (mag == '0)) begin
            res = '0;
        end else if (mag > max_val) begin
            res = max_val;
        end else begin
            res = mag;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slp_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : slp_issue_if
// Brief    : Exec-side request and sleep-unit handshake bundle for slp_issue.
// Revision : 1.0 - initial release
// ============================================================================
interface slp_issue_if
    import slp_issue_pkg::*;
#(
    parameter int TU_W = 16
) ();

    logic                          slp_req;
    logic signed [c_SLP_VAL_W-1:0] slp_operand;
    logic                          slp_ack;
    logic                          exec_stall;
    logic                          wake;
    logic                          slp_err;
    logic        [c_SLP_VAL_W-1:0] sleep_val;
    logic                          input_flag;
    logic                          output_flag;
    logic                          posedge_big_clk;
    logic        [TU_W-1:0]        time_unit;

    // Environment view: exec stage plus sleep unit.
    modport master (
        output slp_req,
        output slp_operand,
        output output_flag,
        input  slp_ack,
        input  exec_stall,
        input  wake,
        input  slp_err,
        input  sleep_val,
        input  input_flag,
        input  posedge_big_clk,
        input  time_unit
    );

    modport slave (
        input  slp_req,
        input  slp_operand,
        input  output_flag,
        output slp_ack,
        output exec_stall,
        output wake,
        output slp_err,
        output sleep_val,
        output input_flag,
        output posedge_big_clk,
        output time_unit
    );

endinterface
`default_nettype wire

// File: rtl/slp_issue_big_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : big_clk_gen
// Brief    : Time-unit divider producing a one-cycle tick and a wrapping count.
// Revision : 1.0 - initial release
// ============================================================================
module big_clk_gen #(
    parameter int CLK_DIV = 16,
    parameter int TU_W    = 16
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              run,
    output logic             posedge_big_clk,
    output logic [TU_W-1:0]  time_unit
);

    localparam int c_CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tick;
    logic [TU_W-1:0]    r_time_unit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_tick      <= 1'b0;
            r_time_unit <= '0;
        end else begin
            r_tick <= 1'b0;
            if (run) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt       <= '0;
                    r_tick      <= 1'b1;
                    r_time_unit <= r_time_unit + TU_W'(1);
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign posedge_big_clk = r_tick;
    assign time_unit       = r_time_unit;

endmodule
`default_nettype wire

// File: rtl/slp_issue.sv
`default_nettype none
// ============================================================================
// Module   : slp_issue
// Brief    : Accepts exec sleep requests, clamps the operand, starts the sleep
//            unit and stalls exec until it finishes.
// Revision : 1.0 - initial release
// ============================================================================
module slp_issue
    import slp_issue_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int TU_W    = 16,
    parameter int SLP_MAX = c_SLP_MAX
) (
    input wire          clk,
    input wire          reset,
    input wire          run,
    slp_issue_if.slave  bus
);

    localparam logic [c_SLP_VAL_W-1:0] c_MAX_VAL = c_SLP_VAL_W'(SLP_MAX);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ack;
    logic                     w_ack_nxt;
    logic                     r_stall;
    logic                     w_stall_nxt;
    logic                     r_wake;
    logic                     w_wake_nxt;
    logic                     r_err;
    logic                     w_err_nxt;
    logic                     r_input_flag;
    logic                     w_input_flag_nxt;
    logic [c_SLP_VAL_W-1:0]   r_sleep_val;
    logic [c_SLP_VAL_W-1:0]   w_sleep_val_nxt;
    logic [c_SLP_VAL_W-1:0]   w_clamped;

    assign w_clamped = clamp_op(bus.slp_operand, c_MAX_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_ack        <= 1'b0;
            r_stall      <= 1'b0;
            r_wake       <= 1'b0;
            r_err        <= 1'b0;
            r_input_flag <= 1'b0;
            r_sleep_val  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ack        <= w_ack_nxt;
            r_stall      <= w_stall_nxt;
            r_wake       <= w_wake_nxt;
            r_err        <= w_err_nxt;
            r_input_flag <= w_input_flag_nxt;
            r_sleep_val  <= w_sleep_val_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ack_nxt        = 1'b0;
        w_stall_nxt      = r_stall;
        w_wake_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_input_flag_nxt = 1'b0;
        w_sleep_val_nxt  = r_sleep_val;
        case (r_state)
            c_ST_IDLE: begin
                w_stall_nxt = 1'b0;
                // While our ack is on the bus exec has not yet dropped the old request.
                if (bus.slp_req && !bus.output_flag && !r_ack) begin
                    w_ack_nxt = 1'b1;
                    if (w_clamped == '0) begin
                        w_wake_nxt = 1'b1;
                    end else begin
                        w_input_flag_nxt = 1'b1;
                        w_sleep_val_nxt  = w_clamped;
                        w_stall_nxt      = 1'b1;
                        w_state_nxt      = c_ST_START;
                    end
                end
            end
            c_ST_START: begin
                // The sleep unit only reacts to input_flag at the end of the issue cycle.
                if (!r_input_flag) begin
                    if (bus.output_flag) begin
                        w_state_nxt = c_ST_SLEEPING;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_wake_nxt  = 1'b1;
                        w_stall_nxt = 1'b0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_SLEEPING: begin
                if (!bus.output_flag) begin
                    w_wake_nxt  = 1'b1;
                    w_stall_nxt = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_stall_nxt = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bus.slp_ack    = r_ack;
    assign bus.exec_stall = r_stall;
    assign bus.wake       = r_wake;
    assign bus.slp_err    = r_err;
    assign bus.input_flag = r_input_flag;
    assign bus.sleep_val  = r_sleep_val;

    big_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .TU_W    (TU_W)
    ) u_big_clk_gen (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .posedge_big_clk (bus.posedge_big_clk),
        .time_unit       (bus.time_unit)
    );

endmodule
`default_nettype wire
